// File: rtl/dx_trng_pkg.sv
// Shared definitions for the ring-oscillator entropy sources: mode and FSM
// encodings plus the per-ring inverter count.
package dx_trng_pkg;

    typedef enum logic [1:0] {
        DX_ROSC_FIXED     = 2'b00,
        DX_ROSC_RR        = 2'b01,
        DX_ROSC_XOR       = 2'b10,
        DX_ROSC_FIXED_ALT = 2'b11
    } rosc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WARMUP = 2'b01,
        ST_SAMPLE = 2'b10,
        ST_FAIL   = 2'b11
    } rosc_state_e;

    function automatic int unsigned ring_len(input int unsigned base_len,
                                             input int unsigned len_step,
                                             input int unsigned idx);
        return base_len + idx * len_step;
    endfunction

endpackage

// File: rtl/dx_rosc_ring.sv
// Gated inverter-chain ring oscillator with a DFT flop that replaces the
// combinational loop closure while scanmode=1.
module DX_GTECH_NOT (
    input  logic a,
    output logic z
);
    assign z = ~a;
endmodule

module dx_rosc_ring #(
    parameter int unsigned LEN = 51
) (
    input  logic rng_clk,
    input  logic rst_n,
    input  logic ring_en,
    input  logic scanmode,
    output logic ring_out
);
    logic [LEN:0] chain;
    logic         loop_in;
    logic         dft_q;

    assign loop_in  = scanmode ? dft_q : chain[LEN];
    assign chain[0] = ring_en & loop_in;

    for (genvar g = 0; g < LEN; g++) begin : g_inv
        DX_GTECH_NOT u_not (
            .a (chain[g]),
            .z (chain[g+1])
        );
    end

    assign ring_out = chain[LEN];

    always_ff @(posedge rng_clk) begin
        if (!rst_n) dft_q <= 1'b0;
        else        dft_q <= chain[LEN];
    end

endmodule

// File: rtl/dx_rosc_entropy_bank.sv
// Bank of NUM_RINGS ring oscillators with warm-up, decimation, source-mode
// selection, valid/ready bit output and a repetition-count health test.
module dx_rosc_entropy_bank
    import dx_trng_pkg::*;
#(
    parameter int unsigned NUM_RINGS    = 4,
    parameter int unsigned BASE_LEN     = 51,
    parameter int unsigned LEN_STEP     = 8,
    parameter int unsigned SAMPLE_CNT_W = 8,
    parameter int unsigned WARMUP_CYC   = 64,
    parameter int unsigned REP_LIMIT    = 32
) (
    input  logic                         rng_clk,
    input  logic                         rst_n,
    input  logic                         rnd_src_en,
    input  logic [1:0]                   mode,
    input  logic [$clog2(NUM_RINGS)-1:0] ring_sel,
    input  logic [SAMPLE_CNT_W-1:0]      sample_cnt,
    input  logic                         scanmode,
    output logic                         bit_out,
    output logic                         bit_valid,
    input  logic                         bit_ready,
    output logic                         busy,
    output logic                         rep_fail
);
    localparam int unsigned SEL_W  = $clog2(NUM_RINGS);
    localparam int unsigned WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int unsigned REP_W  = $clog2(REP_LIMIT + 1);

    rosc_state_e               state_q, state_d;
    rosc_mode_e                mode_q;
    logic [SEL_W-1:0]          ring_idx_q;
    logic [SAMPLE_CNT_W-1:0]   period_q;
    logic [SAMPLE_CNT_W-1:0]   dec_cnt_q;
    logic [WARM_W-1:0]         warm_cnt_q;
    logic [1:0]                sync_q;
    logic [REP_W-1:0]          rep_cnt_q, rep_next;
    logic                      last_bit_q, have_bit_q;

    logic [NUM_RINGS-1:0]      ring_out;
    logic                      ring_en;
    logic                      src_bit;
    logic                      fire, accept, out_free, rep_set, warm_done;

    for (genvar i = 0; i < NUM_RINGS; i++) begin : g_ring
        dx_rosc_ring #(
            .LEN (ring_len(BASE_LEN, LEN_STEP, i))
        ) u_ring (
            .rng_clk  (rng_clk),
            .rst_n    (rst_n),
            .ring_en  (ring_en),
            .scanmode (scanmode),
            .ring_out (ring_out[i])
        );
    end

    assign ring_en   = (state_q == ST_WARMUP) || (state_q == ST_SAMPLE);
    assign busy      = ring_en;
    assign src_bit   = (mode_q == DX_ROSC_XOR) ? ^ring_out : ring_out[ring_idx_q];
    assign warm_done = (warm_cnt_q == WARM_W'(WARMUP_CYC - 1));
    assign fire      = (state_q == ST_SAMPLE) && (dec_cnt_q == SAMPLE_CNT_W'(1));
    assign accept    = bit_valid & bit_ready;
    assign out_free  = ~bit_valid | bit_ready;

    // Run length including the bit being accepted; saturates at REP_LIMIT.
    always_comb begin
        rep_next = REP_W'(1);
        if (have_bit_q && (bit_out == last_bit_q)) begin
            rep_next = (rep_cnt_q == REP_W'(REP_LIMIT)) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
        end
    end

    assign rep_set = accept && (rep_next == REP_W'(REP_LIMIT)) &&
                     (rep_cnt_q != REP_W'(REP_LIMIT));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (rnd_src_en) state_d = ST_WARMUP;
            ST_WARMUP: if (warm_done)  state_d = ST_SAMPLE;
            ST_SAMPLE: if (rep_set)    state_d = ST_FAIL;
            ST_FAIL:   state_d = ST_FAIL;
            default:   state_d = ST_IDLE;
        endcase
        if (!rnd_src_en) state_d = ST_IDLE;
    end

    always_ff @(posedge rng_clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= DX_ROSC_FIXED;
            ring_idx_q <= '0;
            period_q   <= '0;
            dec_cnt_q  <= '0;
            warm_cnt_q <= '0;
            sync_q     <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            rep_cnt_q  <= '0;
            last_bit_q <= 1'b0;
            have_bit_q <= 1'b0;
            rep_fail   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], src_bit};

            if (state_q == ST_WARMUP) begin
                warm_cnt_q <= warm_cnt_q + WARM_W'(1);
                dec_cnt_q  <= period_q;
            end else if (state_q == ST_SAMPLE) begin
                dec_cnt_q  <= fire ? period_q : dec_cnt_q - SAMPLE_CNT_W'(1);
            end

            // A bit that trips the health test is the last one handed out.
            if (!rnd_src_en || rep_set || state_q != ST_SAMPLE) begin
                bit_valid <= 1'b0;
            end else if (fire && out_free) begin
                bit_out   <= sync_q[1];
                bit_valid <= 1'b1;
            end else if (accept) begin
                bit_valid <= 1'b0;
            end

            if (accept && mode_q == DX_ROSC_RR) begin
                ring_idx_q <= (ring_idx_q == SEL_W'(NUM_RINGS - 1)) ? '0
                                                                   : ring_idx_q + SEL_W'(1);
            end

            if (state_q == ST_IDLE) begin
                rep_cnt_q  <= '0;
                have_bit_q <= 1'b0;
                if (rnd_src_en) begin
                    mode_q     <= rosc_mode_e'(mode);
                    ring_idx_q <= ring_sel;
                    period_q   <= (sample_cnt == '0) ? SAMPLE_CNT_W'(1) : sample_cnt;
                    warm_cnt_q <= '0;
                end
            end else if (accept) begin
                rep_cnt_q  <= rep_next;
                last_bit_q <= bit_out;
                have_bit_q <= 1'b1;
            end

            if (rep_set) rep_fail <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dx_rosc_entropy_bank.sv
// Scenario bench for dx_rosc_entropy_bank in scanmode, where ring outputs are
// deterministic; expected bits and ring indices are queued and popped on accept.
module tb_dx_rosc_entropy_bank;
    import dx_trng_pkg::*;

    localparam int unsigned WARMUP_CYC = 64;
    localparam int unsigned REP_LIMIT  = 32;

    logic       clk = 1'b0;
    logic       rst_n, en, scanmode, bit_ready;
    logic [1:0] mode, ring_sel;
    logic [7:0] sample_cnt;
    logic       bit_out, bit_valid, busy, rep_fail;

    int errors = 0;
    int checks = 0;
    logic exp_q[$];
    logic [1:0] exp_idx_q[$];

    dx_rosc_entropy_bank #(
        .NUM_RINGS    (4),
        .BASE_LEN     (51),
        .LEN_STEP     (8),
        .SAMPLE_CNT_W (8),
        .WARMUP_CYC   (WARMUP_CYC),
        .REP_LIMIT    (REP_LIMIT)
    ) dut (
        .rng_clk    (clk),
        .rst_n      (rst_n),
        .rnd_src_en (en),
        .mode       (mode),
        .ring_sel   (ring_sel),
        .sample_cnt (sample_cnt),
        .scanmode   (scanmode),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .busy       (busy),
        .rep_fail   (rep_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic [1:0] m, input logic [1:0] sel,
                               input logic [7:0] scnt, input logic rdy);
        rst_n = 1'b0; en = 1'b1; scanmode = 1'b1;
        mode = m; ring_sel = sel; sample_cnt = scnt; bit_ready = rdy;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int cycles;
        rst_n = 1'b0; en = 1'b1; scanmode = 1'b1; mode = 2'd0; ring_sel = 2'd2;
        sample_cnt = 8'd1; bit_ready = 1'b1;
        tick(); tick();
        checks++; if (bit_out !== 1'b0)   begin errors++; $display("FAIL reset_bit_out got=%b exp=0", bit_out); end
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid got=%b exp=0", bit_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rep_fail !== 1'b0)  begin errors++; $display("FAIL reset_rep_fail got=%b exp=0", rep_fail); end
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_after got=%b exp=1", busy); end
        cycles = 1;
        while (bit_valid !== 1'b1 && cycles < 300) begin tick(); cycles++; end
        checks++;
        if (bit_valid !== 1'b1 || cycles != WARMUP_CYC + 2) begin
            errors++; $display("FAIL first_valid_latency got=%0d exp=%0d", cycles, WARMUP_CYC + 2);
        end
    endtask

    task automatic test_alternating();
        int n = 0, cyc = 0, last_cyc = 0;
        logic prev = 1'b0;
        apply_reset(2'd0, 2'd2, 8'd3, 1'b1);
        while (n < 200 && cyc < 1200) begin
            if (bit_valid && bit_ready) begin
                if (n > 0) begin
                    checks++;
                    if (bit_out === prev) begin errors++; $display("FAIL alt_bit n=%0d got=%b exp=%b", n, bit_out, ~prev); end
                    checks++;
                    if (cyc - last_cyc != 3) begin errors++; $display("FAIL alt_spacing n=%0d got=%0d exp=3", n, cyc - last_cyc); end
                end
                prev = bit_out; last_cyc = cyc; n++;
            end
            tick(); cyc++;
        end
        checks++; if (n != 200)          begin errors++; $display("FAIL alt_count got=%0d exp=200", n); end
        checks++; if (rep_fail !== 1'b0) begin errors++; $display("FAIL alt_rep_fail got=%b exp=0", rep_fail); end
    endtask

    task automatic test_rep_fail();
        int n = 0, cyc = 0;
        logic first = 1'b0;
        logic acc;
        apply_reset(2'd0, 2'd0, 8'd2, 1'b1);
        while (n < REP_LIMIT && cyc < 600) begin
            acc = bit_valid && bit_ready;
            if (acc) begin
                n++;
                if (n == 1) first = bit_out;
                else begin
                    checks++;
                    if (bit_out !== first) begin errors++; $display("FAIL rep_const n=%0d got=%b exp=%b", n, bit_out, first); end
                end
            end
            tick(); cyc++;
            if (acc) begin
                checks++;
                if (rep_fail !== (n >= REP_LIMIT)) begin
                    errors++; $display("FAIL rep_flag n=%0d got=%b exp=%b", n, rep_fail, n >= REP_LIMIT);
                end
            end
        end
        checks++; if (n != REP_LIMIT)     begin errors++; $display("FAIL rep_accepts got=%0d exp=%0d", n, REP_LIMIT); end
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL rep_valid_in_fail got=%b exp=0", bit_valid); end
        checks++; if (dut.state_q !== ST_FAIL) begin errors++; $display("FAIL rep_state got=%0d exp=%0d", dut.state_q, ST_FAIL); end
        repeat (5) tick();
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL rep_valid_hold got=%b exp=0", bit_valid); end
        en = 1'b0;
        tick();
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rep_to_idle got=%0d exp=%0d", dut.state_q, ST_IDLE); end
        checks++; if (rep_fail !== 1'b1) begin errors++; $display("FAIL rep_sticky got=%b exp=1", rep_fail); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rep_busy got=%b exp=0", busy); end
    endtask

    task automatic test_xor();
        int n = 0, cyc = 0;
        logic acc;
        logic e;
        apply_reset(2'd2, 2'd0, 8'd1, 1'b1);
        for (int i = 0; i < int'(REP_LIMIT); i++) exp_q.push_back(1'b0);
        while (n < REP_LIMIT && cyc < 400) begin
            acc = bit_valid && bit_ready;
            if (acc) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL xor_unexpected_bit n=%0d", n); end
                else begin
                    e = exp_q.pop_front();
                    if (bit_out !== e) begin errors++; $display("FAIL xor_bit n=%0d got=%b exp=%b", n, bit_out, e); end
                end
                n++;
            end
            tick(); cyc++;
            if (acc) begin
                checks++;
                if (rep_fail !== (n >= REP_LIMIT)) begin
                    errors++; $display("FAIL xor_rep_flag n=%0d got=%b exp=%b", n, rep_fail, n >= REP_LIMIT);
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL xor_missing got=%0d exp=0", exp_q.size()); end
        checks++; if (dut.state_q !== ST_FAIL) begin errors++; $display("FAIL xor_state got=%0d exp=%0d", dut.state_q, ST_FAIL); end
        exp_q.delete();
    endtask

    task automatic test_round_robin();
        int n = 0, cyc = 0;
        logic held_valid = 1'b0, held_bit = 1'b0;
        logic [1:0] e;
        apply_reset(2'd1, 2'd3, 8'd1, 1'b0);
        exp_idx_q = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        while (n < 8 && cyc < 400) begin
            bit_ready = (cyc % 4 == 3);
            if (bit_valid && bit_ready) begin
                checks++;
                if (exp_idx_q.size() == 0) begin errors++; $display("FAIL rr_unexpected n=%0d", n); end
                else begin
                    e = exp_idx_q.pop_front();
                    if (dut.ring_idx_q !== e) begin errors++; $display("FAIL rr_index n=%0d got=%0d exp=%0d", n, dut.ring_idx_q, e); end
                end
                n++; held_valid = 1'b0;
            end else if (bit_valid) begin
                if (held_valid) begin
                    checks++;
                    if (bit_out !== held_bit) begin errors++; $display("FAIL rr_stable n=%0d got=%b exp=%b", n, bit_out, held_bit); end
                end
                held_bit = bit_out; held_valid = 1'b1;
            end
            tick(); cyc++;
        end
        bit_ready = 1'b0;
        checks++; if (n != 8) begin errors++; $display("FAIL rr_accepts got=%0d exp=8", n); end
        checks++; if (dut.ring_idx_q !== 2'd3) begin errors++; $display("FAIL rr_final_index got=%0d exp=3", dut.ring_idx_q); end
    endtask

    task automatic test_disable();
        int cycles = 0, cyc = 0, last_cyc = 0, n = 0;
        apply_reset(2'd0, 2'd0, 8'd3, 1'b0);
        while (bit_valid !== 1'b1 && cycles < 300) begin tick(); cycles++; end
        checks++; if (bit_valid !== 1'b1) begin errors++; $display("FAIL dis_first_valid got=%b exp=1", bit_valid); end
        en = 1'b0;
        tick();
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL dis_valid got=%b exp=0", bit_valid); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL dis_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
        checks++; if (dut.have_bit_q !== 1'b0) begin errors++; $display("FAIL dis_no_accept got=%b exp=0", dut.have_bit_q); end
        sample_cnt = 8'd0; bit_ready = 1'b1; en = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dis_rewarm_busy got=%b exp=1", busy); end
        cycles = 1;
        while (bit_valid !== 1'b1 && cycles < 300) begin tick(); cycles++; end
        checks++;
        if (bit_valid !== 1'b1 || cycles != WARMUP_CYC + 2) begin
            errors++; $display("FAIL dis_rewarm_latency got=%0d exp=%0d", cycles, WARMUP_CYC + 2);
        end
        while (n < 4 && cyc < 50) begin
            if (bit_valid && bit_ready) begin
                if (n > 0) begin
                    checks++;
                    if (cyc - last_cyc != 1) begin errors++; $display("FAIL dis_cnt0_spacing got=%0d exp=1", cyc - last_cyc); end
                end
                last_cyc = cyc; n++;
            end
            tick(); cyc++;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL dis_cnt0_accepts got=%0d exp=4", n); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; scanmode = 1'b1; bit_ready = 1'b0;
        mode = 2'd0; ring_sel = 2'd0; sample_cnt = 8'd1;
        test_reset();
        test_alternating();
        test_rep_fail();
        test_xor();
        test_round_robin();
        test_disable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
